// File: rtl/btn_pkg.sv
// Shared constants for the button debouncer: FSM state encoding and default timing.
package btn_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } btn_state_t;

  // 10 ms at 100 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Counter width for a given qualification length; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Mechanical button debouncer: synchronizes the raw level, requires DEBOUNCE_CYCLES+1
// consecutive matching samples before accepting a change, and emits edge pulses.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync2;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (sync2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LOW;
      cnt       <= '0;
      btn_clean <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
      unique case (state)
        S_LOW: begin
          if (sync2) begin
            state <= S_WAIT_HI;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_WAIT_HI: begin
          if (!sync2) begin
            // Glitch: drop back with no credit kept.
            state <= S_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= S_HIGH;
            cnt       <= '0;
            busy      <= 1'b0;
            btn_clean <= 1'b1;
            btn_rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!sync2) begin
            state <= S_WAIT_LO;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (sync2) begin
            state <= S_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= S_LOW;
            cnt       <= '0;
            busy      <= 1'b0;
            btn_clean <= 1'b0;
            btn_fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with DEBOUNCE_CYCLES=4: directed latency scenarios plus a random
// bouncing stream checked against a run-length reference model.
module tb_btn_debounce;
  import btn_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_clean, btn_rise, btn_fall, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: raw delayed two samples, then a run of N+1 opposite samples flips the level.
  logic m_s1, m_s2, m_clean, m_rise, m_fall, m_busy;
  int   m_run;

  btn_debounce #(
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_clean (btn_clean),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic raw, input logic rst);
    logic s;
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_run = 0;
    end else begin
      s      = m_s2;
      m_s2   = m_s1;
      m_s1   = raw;
      m_rise = 0;
      m_fall = 0;
      m_run  = (s != m_clean) ? m_run + 1 : 0;
      if (m_run == N + 1) begin
        m_clean = ~m_clean;
        m_rise  = m_clean;
        m_fall  = ~m_clean;
        m_run   = 0;
      end
      m_busy = (m_run != 0);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if ({btn_clean, btn_rise, btn_fall, busy} !== 4'b0000 || dut.state !== S_LOW) begin
        errors++;
        $display("FAIL reset: outputs=%b state=%0d, required 0000 state=0",
                 {btn_clean, btn_rise, btn_fall, busy}, dut.state);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if ({btn_clean, btn_rise, btn_fall, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_after_reset: outputs=%b, required 0000",
                 {btn_clean, btn_rise, btn_fall, busy});
      end
    end
  endtask

  // raw 0->1 at E0 held: busy E2..E5, clean and rise at E6, rise gone at E7.
  task automatic test_clean_press();
    logic [3:0] exp;
    for (int e = 0; e < 10; e++) begin
      tick(1'b1, 1'b0);
      exp = {(e >= 6), (e == 6), 1'b0, (e >= 2 && e <= 5)};
      checks++;
      if ({btn_clean, btn_rise, btn_fall, busy} !== exp) begin
        errors++;
        $display("FAIL clean_press E%0d: {clean,rise,fall,busy}=%b, required %b",
                 e, {btn_clean, btn_rise, btn_fall, busy}, exp);
      end
    end
  endtask

  // From clean=1: raw 1->0 at E0 held -> clean drops and fall at E6, never a rise.
  task automatic test_release();
    logic [3:0] exp;
    for (int e = 0; e < 10; e++) begin
      tick(1'b0, 1'b0);
      exp = {(e < 6), 1'b0, (e == 6), (e >= 2 && e <= 5)};
      checks++;
      if ({btn_clean, btn_rise, btn_fall, busy} !== exp) begin
        errors++;
        $display("FAIL release E%0d: {clean,rise,fall,busy}=%b, required %b",
                 e, {btn_clean, btn_rise, btn_fall, busy}, exp);
      end
    end
  endtask

  // Three high samples then low: rejected as a glitch.
  task automatic test_glitch();
    int pulses = 0;
    for (int e = 0; e < 12; e++) begin
      tick((e < 3) ? 1'b1 : 1'b0, 1'b0);
      if (btn_rise || btn_fall || btn_clean) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch: activity_cycles=%0d busy=%b, required 0 and 0", pulses, busy);
    end
  endtask

  // Samples 1,0,1,1,... : final 0->1 at E2, so the single rise lands at E8.
  task automatic test_bounce();
    int pulses = 0;
    int rise_at = -1;
    for (int e = 0; e < 14; e++) begin
      tick((e == 1) ? 1'b0 : 1'b1, 1'b0);
      if (btn_rise || btn_fall) pulses++;
      if (btn_rise && rise_at < 0) rise_at = e;
    end
    checks++;
    if (pulses != 1 || rise_at != 8 || btn_clean !== 1'b1) begin
      errors++;
      $display("FAIL bounce: pulses=%0d rise_at=E%0d clean=%b, required 1, E8, 1",
               pulses, rise_at, btn_clean);
    end
  endtask

  // Press interrupted by reset at E4; raw stays high, so a full requalification follows.
  task automatic test_reset_mid();
    int rise_at = -1;
    for (int e = 0; e < 6; e++) tick(1'b0, 1'b0);
    for (int e = 0; e < 4; e++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    checks++;
    if ({btn_clean, btn_rise, btn_fall, busy} !== 4'b0000 || dut.state !== S_LOW) begin
      errors++;
      $display("FAIL reset_mid E4: outputs=%b state=%0d, required 0000 state=0",
               {btn_clean, btn_rise, btn_fall, busy}, dut.state);
    end
    for (int e = 0; e < 10; e++) begin
      tick(1'b1, 1'b0);
      if (btn_rise && rise_at < 0) rise_at = e;
    end
    checks++;
    if (rise_at != 6 || btn_clean !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid requal: rise_at=+%0d clean=%b, required +6 and 1",
               rise_at, btn_clean);
    end
  endtask

  // Random bouncing levels with occasional resets, compared cycle by cycle with the model.
  task automatic test_random();
    logic lvl = 1'b0;
    logic prev_pulse = 1'b0;
    int   len;
    tick(1'b0, 1'b1);
    for (int seg = 0; seg < 120; seg++) begin
      lvl = ~lvl;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        tick(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        checks++;
        if ({btn_clean, btn_rise, btn_fall, busy} !== {m_clean, m_rise, m_fall, m_busy}) begin
          errors++;
          $display("FAIL random seg%0d: {clean,rise,fall,busy}=%b, required %b", seg,
                   {btn_clean, btn_rise, btn_fall, busy}, {m_clean, m_rise, m_fall, m_busy});
        end
        checks++;
        if ((btn_rise && btn_fall) || (prev_pulse && (btn_rise || btn_fall))) begin
          errors++;
          $display("FAIL pulse_spacing seg%0d: rise=%b fall=%b prev_pulse=%b, required isolated",
                   seg, btn_rise, btn_fall, prev_pulse);
        end
        prev_pulse = btn_rise | btn_fall;
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_glitch();
    test_bounce();
    test_release();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
